bc_score_engine: RTL
====================

# bc_score_engine

Scoring sequencer for the Bulls and Cows game. On a start pulse it captures a 4-digit secret and guess from the game FSM and checks the guess digits for legality. Unless a check-only pass is requested, it then scores one guess position per cycle and reports bulls, cows and win back to the FSM. The game FSM uses it for two jobs: secret validation in the setup states, and scoring in the result state.

## Interface
- No parameters; sizes are fixed constants in `bc_pkg`.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `check_only`  in  1  sampled with `start`; 1 = legality check only, no scoring.
- `secret`  in  16  secret digits; nibble [15:12] is position 0, [3:0] is position 3.
- `guess`  in  16  guess digits (or candidate secret when `check_only`=1); same nibble order as `secret`.
- `busy`  out  1  high in CHECK, SCORE and DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `valid`  out  1  captured guess was legal; held until the next accepted start.
- `bulls`  out  3  0..4; held until the next accepted start.
- `cows`  out  3  0..4; held until the next accepted start.
- `win`  out  1  `valid` && `bulls`==4; held with the results.

## Operation
- States: IDLE, CHECK, SCORE, DONE.
- IDLE, `start`=1:
  - Latch `secret`, `guess` and `check_only`.
  - Clear `bulls`, `cows`, `valid` and `win`.
  - Go to CHECK.
- `start` outside IDLE is ignored: no latch, no state change.
- CHECK:
  - The guess is legal iff every nibble is ≤ 9 and all four nibbles are pairwise distinct.
  - Register the result into `valid`.
  - Illegal guess, or `check_only`=1: go to DONE with `bulls`=`cows`=0.
  - Otherwise: go to SCORE with index i=0.
- SCORE (4 cycles, i = 0..3):
  - bull: guess digit i equals secret digit i; `bulls` += 1.
  - cow: otherwise, guess digit i equals any other secret digit; `cows` += 1.
  - At most one increment per cycle.
  - At i=3, go to DONE.
- DONE (1 cycle): `done`=1, `win` updated, then go to IDLE.
- The secret is not validated during scoring; the FSM is responsible for validating it earlier with `check_only`.
- Counter width: 3 bits is sufficient, since `bulls`+`cows` ≤ 4. No saturation logic is needed.
- Reset, including mid-operation:
  - State goes to IDLE.
  - All outputs go to 0: `busy`, `done`, `valid`, `bulls`, `cows`, `win`.
  - Latched operands are cleared.

## Timing
- Let edge k be the edge at which `start` is sampled in IDLE.
- Scoring path:
  - CHECK during cycle k..k+1.
  - SCORE i=0..3 during k+1..k+5.
  - DONE during k+5..k+6, with `done` high.
  - `bulls`/`cows` are final from edge k+5.
- Check-only or illegal-guess path: DONE during k+1..k+2; `valid` is final from edge k+1.
- `busy` rises at edge k and falls at the edge that leaves DONE.
- Earliest back-to-back start: a start sampled at the DONE→IDLE edge is not accepted. It is accepted one cycle later, in IDLE.
- Outputs are registered, with no combinational paths from input to output.
- `done` is never high for two consecutive cycles.

## Structure
- `bc_pkg` contents:
  - `state_t` enum (IDLE, CHECK, SCORE, DONE).
  - `NUM_DIGITS`=4.
  - `DIGIT_MAX`=4'd9.
  - `NULL_DIGIT`=4'hF.
  - A `digit_t` 4-bit typedef.
  - Nibble-extract function `get_digit(word, pos)`.
- Sub-module `bc_digit_compare`: combinational. Inputs are one guess digit, its position and the 16-bit secret. Outputs are `is_bull` and `is_cow`, which are mutually exclusive. It is instantiated once and driven by index i.
- Top level holds the FSM, index counter, operand registers and result registers.

## Test plan
- secret 0x1234, guess 0x1234, start at edge k:
  - `done` high during k+5..k+6.
  - `bulls`=4, `cows`=0, `valid`=1, `win`=1.
- secret 0x1234, guess 0x4321 → `bulls`=0, `cows`=4, `win`=0. Repeat with guess 0x1243 → `bulls`=2, `cows`=2.
- guess 0x1123 or 0x12A4:
  - `done` during k+1..k+2.
  - `valid`=0, `bulls`=`cows`=0, `win`=0.
- `check_only`=1, guess 0x5678 → `done` during k+1..k+2, `valid`=1, `bulls`=`cows`=0. With 0x5578 → `valid`=0.
- `start` held high throughout a scoring run:
  - Only one run occurs.
  - The next accepted start is at the first IDLE edge after DONE.
  - Results stay stable between runs.
- `reset` asserted during SCORE i=2:
  - The next cycle shows IDLE with all outputs 0.
  - A following start scores correctly from zero.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared types and constants for the Bulls and Cows scoring engine.
// Digit position 0 is the most significant nibble of a 16-bit word.
package bc_pkg;
  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] NULL_DIGIT = 4'hF;

  typedef logic [3:0] digit_t;

  typedef enum logic [1:0] {IDLE, CHECK, SCORE, DONE} state_t;

  function automatic digit_t get_digit(input logic [15:0] word, input logic [1:0] pos);
    logic [15:0] sh;
    sh = word << {pos, 2'b00};
    return sh[15:12];
  endfunction
endpackage

// File: rtl/bc_digit_compare.sv
// Classifies one guess digit against the whole secret as bull, cow or neither.
module bc_digit_compare
  import bc_pkg::*;
(
  input  digit_t      digit,
  input  logic [1:0]  pos,
  input  logic [15:0] secret,
  output logic        is_bull,
  output logic        is_cow
);
  logic any_other;

  always_comb begin
    any_other = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (2'(j) != pos && get_digit(secret, 2'(j)) == digit) any_other = 1'b1;
    end
    is_bull = (get_digit(secret, pos) == digit);
    // A bull takes priority so the two flags never assert together.
    is_cow  = !is_bull && any_other;
  end
endmodule

// File: rtl/bc_score_engine.sv
// Scoring sequencer: legality check of the guess, then one position scored per cycle.
// All outputs come straight from registers.
module bc_score_engine
  import bc_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        check_only,
  input  logic [15:0] secret,
  input  logic [15:0] guess,
  output logic        busy,
  output logic        done,
  output logic        valid,
  output logic [2:0]  bulls,
  output logic [2:0]  cows,
  output logic        win
);
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] secret_q, secret_d;
  logic [15:0] guess_q, guess_d;
  logic        chk_only_q, chk_only_d;
  logic        valid_q, valid_d;
  logic [2:0]  bulls_q, bulls_d;
  logic [2:0]  cows_q, cows_d;
  logic        win_q, win_d;

  logic        legal;
  logic        is_bull, is_cow;

  bc_digit_compare u_cmp (
    .digit   (get_digit(guess_q, idx_q)),
    .pos     (idx_q),
    .secret  (secret_q),
    .is_bull (is_bull),
    .is_cow  (is_cow)
  );

  // Legal: every digit decimal and all four pairwise distinct.
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (get_digit(guess_q, 2'(i)) > DIGIT_MAX) legal = 1'b0;
      for (int j = i + 1; j < NUM_DIGITS; j++) begin
        if (get_digit(guess_q, 2'(i)) == get_digit(guess_q, 2'(j))) legal = 1'b0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    secret_d   = secret_q;
    guess_d    = guess_q;
    chk_only_d = chk_only_q;
    valid_d    = valid_q;
    bulls_d    = bulls_q;
    cows_d     = cows_q;
    win_d      = win_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          secret_d   = secret;
          guess_d    = guess;
          chk_only_d = check_only;
          valid_d    = 1'b0;
          bulls_d    = 3'd0;
          cows_d     = 3'd0;
          win_d      = 1'b0;
          state_d    = CHECK;
        end
      end
      CHECK: begin
        valid_d = legal;
        idx_d   = 2'd0;
        state_d = (!legal || chk_only_q) ? DONE : SCORE;
      end
      SCORE: begin
        if (is_bull)     bulls_d = bulls_q + 3'd1;
        else if (is_cow) cows_d  = cows_q + 3'd1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // win is settled on entry to DONE so it is valid alongside done.
          win_d   = valid_q && (bulls_d == 3'd4);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      secret_q   <= 16'h0000;
      guess_q    <= 16'h0000;
      chk_only_q <= 1'b0;
      valid_q    <= 1'b0;
      bulls_q    <= 3'd0;
      cows_q     <= 3'd0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      secret_q   <= secret_d;
      guess_q    <= guess_d;
      chk_only_q <= chk_only_d;
      valid_q    <= valid_d;
      bulls_q    <= bulls_d;
      cows_q     <= cows_d;
      win_q      <= win_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign valid = valid_q;
  assign bulls = bulls_q;
  assign cows  = cows_q;
  assign win   = win_q;
endmodule
